// File: rtl/glm_sbox_layer_ctrl.sv
// glm_sbox_layer_ctrl: feeds a masked PRINCE state nibble-wise through one shared S-box core.
// Optional build macro GLM_SHARE_CLEAR_EN scrubs the core inputs whenever no nibble is fed.
module glm_sbox_layer_ctrl #(
   parameter int NIBBLES  = 16,
   parameter int CORE_LAT = 2,
   parameter int RND_W    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic [4*NIBBLES-1:0]   in_sh0_i,
   input  logic [4*NIBBLES-1:0]   in_sh1_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [4*NIBBLES-1:0]   out_sh0_o,
   output logic [4*NIBBLES-1:0]   out_sh1_o,
   output logic [3:0]             core_x0_o,
   output logic [3:0]             core_x1_o,
   output logic [RND_W-1:0]       core_rnd_o,
   output logic [CORE_LAT-1:0]    core_en_o,
   input  logic [3:0]             core_y0_i,
   input  logic [3:0]             core_y1_i,
   input  logic [RND_W-1:0]       rnd_i,
   input  logic                   rnd_valid_i,
   output logic                   rnd_ready_o
);

   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2(NIBBLES + 1);
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
   localparam logic [CW-1:0] FULL = CW'(NIBBLES);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t              state_q, state_d;
   logic [W-1:0]        in0_q, in1_q, out0_q, out1_q;
   logic [CW-1:0]       feed_cnt_q, wb_cnt_q;
   logic [CORE_LAT-1:0] vld_q;
   logic [CORE_LAT:0]   vld;
   logic                feed, wb, start, last_feed;

   assign feed      = (state_q == FEED) && rnd_valid_i;
   assign vld       = {vld_q, feed};
   assign wb        = vld[CORE_LAT];
   assign start     = (state_q == IDLE) && start_i;
   assign last_feed = feed && (feed_cnt_q == LAST);

   assign busy_o      = (state_q == FEED) || (state_q == DRAIN);
   assign done_o      = (state_q == DONE);
   assign rnd_ready_o = feed;
   assign core_en_o   = vld[CORE_LAT-1:0];
   assign out_sh0_o   = out0_q;
   assign out_sh1_o   = out1_q;

`ifdef GLM_SHARE_CLEAR_EN
   logic done_enter;
   assign done_enter = (state_d == DONE) && (state_q != DONE);
   assign core_x0_o  = feed ? in0_q[3:0] : 4'h0;
   assign core_x1_o  = feed ? in1_q[3:0] : 4'h0;
   assign core_rnd_o = feed ? rnd_i : '0;
`else
   assign core_x0_o  = in0_q[3:0];
   assign core_x1_o  = in1_q[3:0];
   assign core_rnd_o = (state_q == FEED) ? rnd_i : '0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state: last write-back moves DRAIN straight into DONE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start_i) state_d = FEED;
         FEED:  if (last_feed) state_d = DRAIN;
         DRAIN: if ((wb_cnt_q == FULL) || (wb && (wb_cnt_q == LAST)))
                   state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // input share shift registers and feed counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in0_q      <= '0;
         in1_q      <= '0;
         feed_cnt_q <= '0;
      end else if (start) begin
         in0_q      <= in_sh0_i;
         in1_q      <= in_sh1_i;
         feed_cnt_q <= '0;
      end else if (feed) begin
         in0_q      <= {4'h0, in0_q[W-1:4]};
         in1_q      <= {4'h0, in1_q[W-1:4]};
         feed_cnt_q <= feed_cnt_q + CW'(1);
`ifdef GLM_SHARE_CLEAR_EN
      end else if (done_enter) begin
         in0_q      <= '0;
         in1_q      <= '0;
`endif
      end
   end

   // valid pipe tracking nibbles inside the core
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld[CORE_LAT-1:0];
   end

   // write-back: core results enter at the top, LSB nibble first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out0_q   <= '0;
         out1_q   <= '0;
         wb_cnt_q <= '0;
      end else if (start) begin
         wb_cnt_q <= '0;
      end else if (wb) begin
         out0_q   <= {core_y0_i, out0_q[W-1:4]};
         out1_q   <= {core_y1_i, out1_q[W-1:4]};
         wb_cnt_q <= wb_cnt_q + CW'(1);
      end
   end

endmodule

// File: tb/tb_glm_sbox_layer_ctrl.sv
// tb_glm_sbox_layer_ctrl: random and directed layers against a nibble-level model.
// A two-stage XOR-with-randomness core stands in for the masked S-box.
module tb_glm_sbox_layer_ctrl;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        start_i = 0;
   logic [63:0] in_sh0_i = '0, in_sh1_i = '0;
   logic        busy_o, done_o, rnd_ready_o;
   logic [63:0] out_sh0_o, out_sh1_o;
   logic [3:0]  core_x0_o, core_x1_o, core_rnd_o;
   logic [1:0]  core_en_o;
   logic [3:0]  core_y0_i, core_y1_i;
   logic [3:0]  rnd_i = '0;
   logic        rnd_valid_i = 0;

   int nchk = 0;
   int nerr = 0;

   bit         vpat [0:79];
   logic [3:0] rv   [0:79];

   glm_sbox_layer_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i),
      .in_sh0_i(in_sh0_i), .in_sh1_i(in_sh1_i),
      .busy_o(busy_o), .done_o(done_o),
      .out_sh0_o(out_sh0_o), .out_sh1_o(out_sh1_o),
      .core_x0_o(core_x0_o), .core_x1_o(core_x1_o),
      .core_rnd_o(core_rnd_o), .core_en_o(core_en_o),
      .core_y0_i(core_y0_i), .core_y1_i(core_y1_i),
      .rnd_i(rnd_i), .rnd_valid_i(rnd_valid_i),
      .rnd_ready_o(rnd_ready_o)
   );

   always #5 clk = ~clk;

   logic [3:0] s1a, s1b, s2a, s2b;

   // environment core: y = x ^ r, two enabled register stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1a <= '0; s1b <= '0; s2a <= '0; s2b <= '0;
      end else begin
         if (core_en_o[0]) begin
            s1a <= core_x0_o ^ core_rnd_o;
            s1b <= core_x1_o ^ core_rnd_o;
         end
         if (core_en_o[1]) begin
            s2a <= s1a;
            s2b <= s1b;
         end
      end
   end
   assign core_y0_i = s2a;
   assign core_y1_i = s2b;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_layer(input logic [63:0] a, input logic [63:0] b,
                            input bit pulse);
      int fc [16];
      int k, last, dexp;
      bit isf, prevf;
      logic [63:0] e0, e1;
      k = 0;
      for (int i = 1; i < 80; i++)
         if (vpat[i] && k < 16) begin fc[k] = i; k++; end
      last = fc[15];
      dexp = last + 3;
      for (int j = 0; j < 16; j++) begin
         e0[4*j +: 4] = a[4*j +: 4] ^ rv[fc[j]];
         e1[4*j +: 4] = b[4*j +: 4] ^ rv[fc[j]];
      end
      @(negedge clk);
      in_sh0_i = a; in_sh1_i = b; start_i = 1;
      @(posedge clk); #1;
      start_i = 0; k = 0; prevf = 0;
      for (int c = 1; c <= dexp + 1; c++) begin
         rnd_valid_i = vpat[c];
         rnd_i = rv[c];
         start_i = pulse && (c == 5 || c == dexp);
         isf = (k < 16) && vpat[c];
         @(negedge clk);
         check("rdy", rnd_ready_o, isf);
         check("en0", core_en_o[0], isf);
         check("en1", core_en_o[1], prevf);
         check("done", done_o, c == dexp);
         check("busy", busy_o, c < dexp);
         if (c <= last && !vpat[c]) begin
`ifdef GLM_SHARE_CLEAR_EN
            check("bub_x0", core_x0_o, 0);
            check("bub_x1", core_x1_o, 0);
            check("bub_rnd", core_rnd_o, 0);
`else
            check("bub_x0", core_x0_o, a[4*k +: 4]);
            check("bub_x1", core_x1_o, b[4*k +: 4]);
            check("bub_rnd", core_rnd_o, rv[c]);
`endif
         end
         if (c == dexp + 1) begin
            check("idle_x", {core_x0_o, core_x1_o, core_rnd_o}, 0);
         end
         if (isf) k++;
         prevf = isf;
         @(posedge clk); #1;
      end
      start_i = 0;
      rnd_valid_i = 0;
      check("out0", out_sh0_o, e0);
      check("out1", out_sh1_o, e1);
   endtask

   task automatic plain_pattern();
      for (int i = 0; i < 80; i++) begin vpat[i] = 1; rv[i] = 4'h0; end
   endtask

   initial begin
      #12;
      check("rst_out0", out_sh0_o, 0);
      check("rst_out1", out_sh1_o, 0);
      check("rst_misc", {busy_o, done_o, core_x0_o, core_x1_o,
                         core_rnd_o, core_en_o, rnd_ready_o}, 0);
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle", {busy_o, done_o}, 0);
      end

      plain_pattern();
      run_layer(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 0);

      plain_pattern();
      vpat[3] = 0; vpat[4] = 0; vpat[10] = 0;
      run_layer(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 0);

      plain_pattern();
      run_layer(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1);

      // reset in cycle 8 of a layer
      plain_pattern();
      @(negedge clk);
      in_sh0_i = 64'hA5A5A5A5A5A5A5A5; in_sh1_i = 64'h5A5A5A5A5A5A5A5A;
      start_i = 1;
      @(posedge clk); #1;
      start_i = 0; rnd_valid_i = 1;
      repeat (7) @(posedge clk);
      #2 rst_n = 0;
      #1;
      check("arst_out0", out_sh0_o, 0);
      check("arst_out1", out_sh1_o, 0);
      check("arst_misc", {busy_o, done_o, core_x0_o, core_x1_o,
                          core_rnd_o, core_en_o, rnd_ready_o}, 0);
      rnd_valid_i = 0;
      #1 rst_n = 1;
      run_layer(64'h0F1E2D3C4B5A6978, 64'h8796A5B4C3D2E1F0, 0);

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 80; i++) begin
            vpat[i] = (i > 40) ? 1'b1 : ($urandom_range(3) != 0);
            rv[i] = 4'($urandom);
         end
         run_layer({$urandom, $urandom}, {$urandom, $urandom},
                   1'($urandom_range(1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
